// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready requesters.
// Grants one requester for up to BURST_LEN beats; stalls (holds grant) while the FIFO is full.
`timescale 1ns/1ps
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int GW         = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          grant_valid,
  output logic [GW-1:0]                 grant_id,
  output logic [15:0]                   xfer_count
);

  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_grant_id;
  logic [GW-1:0]   r_last_id;
  logic [BW-1:0]   r_beat_cnt;
  logic [15:0]     r_xfer_count;

  logic            w_found;
  logic [GW-1:0]   w_winner;
  logic            w_in_grant;
  logic            w_cur_valid;
  logic            w_xfer;
  logic            w_last_beat;

  // Handshake: a beat moves when req_valid[i] & req_ready[i]; that is exactly fifo_wr_en.
  // Search order starts one past the previous grantee and wraps.
  always_comb begin
    int          idx_v;
    logic [GW-1:0] cand;
    w_found  = 1'b0;
    w_winner = '0;
    idx_v    = 0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_v = (int'(r_last_id) + k) % NUM_REQ;
      cand  = idx_v[GW-1:0];
      if (!w_found && req_valid[cand]) begin
        w_found  = 1'b1;
        w_winner = cand;
      end
    end
  end

  assign w_in_grant  = (r_state == S_GRANT);
  assign w_cur_valid = req_valid[r_grant_id];
  assign w_xfer      = w_in_grant & w_cur_valid & ~fifo_full;
  assign w_last_beat = (r_beat_cnt == BW'(BURST_LEN - 1));

  always_comb begin
    req_ready    = '0;
    fifo_wr_data = '0;
    if (w_in_grant) begin
      req_ready[r_grant_id] = ~fifo_full;
      fifo_wr_data          = req_data[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign fifo_wr_en  = w_xfer;
  assign grant_valid = w_in_grant;
  assign grant_id    = r_grant_id;
  assign xfer_count  = r_xfer_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_grant_id   <= '0;
      r_last_id    <= GW'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
      r_xfer_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state    <= S_GRANT;
            r_grant_id <= w_winner;
            r_beat_cnt <= '0;
          end
        end
        S_GRANT: begin
          if (w_xfer) begin
            r_beat_cnt   <= r_beat_cnt + BW'(1);
            r_xfer_count <= r_xfer_count + 16'd1;
            if (w_last_beat) begin
              r_state   <= S_IDLE;
              r_last_id <= r_grant_id;
            end
          end else if (!w_cur_valid) begin
            // Withdrawal releases even under full; a full stall alone never does.
            r_state   <= S_IDLE;
            r_last_id <= r_grant_id;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed scenario bench for fifo_write_arbiter; written beats are checked against an expected queue.
`timescale 1ns/1ps
module tb_fifo_write_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int BL = 4;
  localparam int GW = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_wr_data;
  logic             grant_valid;
  logic [GW-1:0]    grant_id;
  logic [15:0]      xfer_count;

  // second instance with long bursts for the counter wrap run
  logic [NR-1:0]    wp_valid;
  logic [NR*DW-1:0] wp_data;
  logic [NR-1:0]    wp_ready;
  logic             wp_full;
  logic             wp_wr_en;
  logic [DW-1:0]    wp_wr_data;
  logic             wp_grant_valid;
  logic [GW-1:0]    wp_grant_id;
  logic [15:0]      wp_xfer_count;

  fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .grant_valid(grant_valid), .grant_id(grant_id),
    .xfer_count(xfer_count)
  );

  fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(64)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .req_valid(wp_valid), .req_data(wp_data),
    .req_ready(wp_ready), .fifo_full(wp_full), .fifo_wr_en(wp_wr_en),
    .fifo_wr_data(wp_wr_data), .grant_valid(wp_grant_valid), .grant_id(wp_grant_id),
    .xfer_count(wp_xfer_count)
  );

  // scoreboard
  logic [GW+DW-1:0] exp_q[$];
  int               n_checks = 0;
  int               n_pass   = 0;
  int               seq[NR];
  int               exp_idx[NR];
  logic [7:0]       seed[NR];
  int               exp_xfer;
  logic             last_wr;
  logic [NR-1:0]    last_ready;

  function automatic logic [7:0] data_of(int i, int k);
    return 8'(int'(seed[i]) + k * 13 + i * 64);
  endfunction

  task automatic push_exp(int id, int n);
    for (int j = 0; j < n; j++) begin
      exp_q.push_back({GW'(id), data_of(id, exp_idx[id])});
      exp_idx[id]++;
      exp_xfer++;
    end
  endtask

  // One cycle: present data, sample just after the negedge, compare any write, advance accepted requesters.
  task automatic tick();
    logic [GW+DW-1:0] e;
    logic [NR-1:0]    acc;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = data_of(i, seq[i]);
    #1;
    last_wr    = fifo_wr_en;
    last_ready = req_ready;
    if (fifo_wr_en) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL wr_unexpected: got write id %0d data %02h, expected no write", grant_id, fifo_wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({grant_id, fifo_wr_data} !== e)
          $display("FAIL wr_beat: got id %0d data %02h, expected id %0d data %02h",
                   grant_id, fifo_wr_data, e[GW+DW-1:DW], e[DW-1:0]);
        else n_pass++;
      end
    end
    acc = req_valid & req_ready;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NR; i++) if (acc[i]) seq[i]++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; fifo_full = 1'b0; req_valid = '1; req_data = '0;
    #2;
    n_checks++; if (fifo_wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b expected 0", fifo_wr_en); else n_pass++;
    n_checks++; if (req_ready !== 4'b0) $display("FAIL rst_ready: got %b expected 0000", req_ready); else n_pass++;
    n_checks++; if (grant_valid !== 1'b0) $display("FAIL rst_grant_valid: got %b expected 0", grant_valid); else n_pass++;
    n_checks++; if (xfer_count !== 16'h0) $display("FAIL rst_xfer_count: got %h expected 0000", xfer_count); else n_pass++;
    n_checks++; if (fifo_wr_data !== 8'h0) $display("FAIL rst_wr_data: got %h expected 00", fifo_wr_data); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    n_checks++;
    if ({grant_valid, grant_id} !== {1'b1, 2'd0})
      $display("FAIL first_grant: got valid %b id %0d expected valid 1 id 0", grant_valid, grant_id);
    else n_pass++;
    push_exp(0, 2);
    tick(); tick();
    n_checks++; if (xfer_count !== 16'(exp_xfer)) $display("FAIL pre_rst_count: got %0d expected %0d", xfer_count, exp_xfer); else n_pass++;
    // mid-burst asynchronous reset
    reset_n = 1'b0;
    #1;
    exp_xfer = 0;
    n_checks++; if (fifo_wr_en !== 1'b0) $display("FAIL mid_rst_wr_en: got %b expected 0", fifo_wr_en); else n_pass++;
    n_checks++; if (req_ready !== 4'b0) $display("FAIL mid_rst_ready: got %b expected 0000", req_ready); else n_pass++;
    n_checks++; if (grant_valid !== 1'b0) $display("FAIL mid_rst_grant: got %b expected 0", grant_valid); else n_pass++;
    n_checks++; if (xfer_count !== 16'h0) $display("FAIL mid_rst_count: got %h expected 0000", xfer_count); else n_pass++;
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    n_checks++; if (exp_q.size() != 0) $display("FAIL rst_drain: got %0d pending beats expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_single_burst();
    int base;
    logic [7:0] pat;
    base = seq[2];
    push_exp(2, 6);
    for (int t = 0; t < 8; t++) begin
      req_valid = '0;
      req_valid[2] = (seq[2] - base) < 6;
      tick();
      pat[t] = last_wr;
    end
    n_checks++; if (pat !== 8'b1101_1110) $display("FAIL single_pattern: got %b expected 11011110", pat); else n_pass++;
    req_valid = '0;
    req_valid[2] = (seq[2] - base) < 6;
    tick();
    n_checks++; if (xfer_count !== 16'(exp_xfer)) $display("FAIL single_count: got %0d expected %0d", xfer_count, exp_xfer); else n_pass++;
    n_checks++;
    if ({grant_valid, grant_id} !== {1'b0, 2'd2})
      $display("FAIL single_release: got valid %b id %0d expected valid 0 id 2", grant_valid, grant_id);
    else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL single_drain: got %0d pending expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [24:0] pat, exp_pat;
    reset_n = 1'b0;
    #1;
    exp_xfer = 0;
    reset_n = 1'b1;
    for (int r = 0; r < 5; r++) push_exp(r % NR, BL);
    req_valid = '1;
    for (int t = 0; t < 25; t++) begin
      tick();
      pat[t]     = last_wr;
      exp_pat[t] = (t % 5) != 0;
    end
    n_checks++; if (pat !== exp_pat) $display("FAIL rr_pattern: got %b expected %b", pat, exp_pat); else n_pass++;
    req_valid = '0;
    tick();
    n_checks++; if (exp_q.size() != 0) $display("FAIL rr_drain: got %0d pending expected 0", exp_q.size()); else n_pass++;
    n_checks++; if (xfer_count !== 16'(exp_xfer)) $display("FAIL rr_count: got %0d expected %0d", xfer_count, exp_xfer); else n_pass++;
  endtask

  task automatic test_full_stall();
    req_valid = 4'b0010;
    push_exp(1, 4);
    tick(); tick(); tick();
    for (int s = 0; s < 3; s++) begin
      fifo_full = 1'b1;
      tick();
      n_checks++; if (last_wr !== 1'b0) $display("FAIL stall_wr_en: got %b expected 0", last_wr); else n_pass++;
      n_checks++; if (last_ready !== 4'b0) $display("FAIL stall_ready: got %b expected 0000", last_ready); else n_pass++;
      n_checks++;
      if ({grant_valid, grant_id} !== {1'b1, 2'd1})
        $display("FAIL stall_grant: got valid %b id %0d expected valid 1 id 1", grant_valid, grant_id);
      else n_pass++;
    end
    fifo_full = 1'b0;
    tick(); tick();
    n_checks++; if (grant_valid !== 1'b0) $display("FAIL stall_release: got %b expected 0", grant_valid); else n_pass++;
    req_valid = '0;
    tick();
    n_checks++; if (exp_q.size() != 0) $display("FAIL stall_drain: got %0d pending expected 0", exp_q.size()); else n_pass++;
    n_checks++; if (xfer_count !== 16'(exp_xfer)) $display("FAIL stall_count: got %0d expected %0d", xfer_count, exp_xfer); else n_pass++;
  endtask

  task automatic test_withdraw();
    req_valid = 4'b0001;
    tick();
    n_checks++;
    if ({grant_valid, grant_id} !== {1'b1, 2'd0})
      $display("FAIL wd_grant0: got valid %b id %0d expected valid 1 id 0", grant_valid, grant_id);
    else n_pass++;
    push_exp(0, 2);
    req_valid = 4'b1001;
    tick(); tick();
    req_valid = 4'b1000;
    tick();
    n_checks++; if (last_wr !== 1'b0) $display("FAIL wd_no_write: got %b expected 0", last_wr); else n_pass++;
    n_checks++; if (grant_valid !== 1'b0) $display("FAIL wd_idle: got %b expected 0", grant_valid); else n_pass++;
    tick();
    n_checks++;
    if ({grant_valid, grant_id} !== {1'b1, 2'd3})
      $display("FAIL wd_grant3: got valid %b id %0d expected valid 1 id 3", grant_valid, grant_id);
    else n_pass++;
    push_exp(3, 4);
    for (int t = 0; t < 4; t++) tick();
    req_valid = '0;
    tick();
    n_checks++; if (exp_q.size() != 0) $display("FAIL wd_drain: got %0d pending expected 0", exp_q.size()); else n_pass++;
    n_checks++; if (xfer_count !== 16'(exp_xfer)) $display("FAIL wd_count: got %0d expected %0d", xfer_count, exp_xfer); else n_pass++;
  endtask

  task automatic test_wrap();
    int n, cyc;
    n = 0; cyc = 0;
    wp_valid = 4'b0001;
    while (n < 65536 && cyc < 70000) begin
      #1;
      if (wp_wr_en) n++;
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (n != 65536) $display("FAIL wrap_budget: got %0d beats expected 65536", n); else n_pass++;
    n_checks++; if (wp_xfer_count !== 16'h0000) $display("FAIL wrap_count: got %h expected 0000", wp_xfer_count); else n_pass++;
    cyc = 0;
    while (n < 65539 && cyc < 100) begin
      #1;
      if (wp_wr_en) n++;
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (wp_xfer_count !== 16'h0003) $display("FAIL wrap_continue: got %h expected 0003", wp_xfer_count); else n_pass++;
    wp_valid = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      seed[i]    = 8'($urandom_range(0, 255));
      seq[i]     = 0;
      exp_idx[i] = 0;
    end
    exp_xfer = 0;
    wp_valid = '0; wp_data = '0; wp_full = 1'b0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_withdraw();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write-side arbiter that shares one FIFO write port (`wr_en`/`wr_data`/`full` of the team's FIFOs) among `NUM_REQ` requesters in the FIFO's write-clock domain. Each requester presents data with a valid/ready handshake. The arbiter grants one requester at a time for a bounded burst, then forwards beats to the FIFO only while it is not full. It sits directly in front of the FIFO write port; the read side is untouched.

## Interface

- `NUM_REQ`, 4: number of requesters, at least 2.
- `DATA_WIDTH`, 8: data width; must match the FIFO.
- `BURST_LEN`, 4: maximum beats per grant, at least 1.
- `GW`, derived: `$clog2(NUM_REQ)`.
- `clk`  in  1: single clock, the FIFO write clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ: per-requester valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH: requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready`  out  NUM_REQ: per-requester ready; one-hot or zero.
- `fifo_full`  in  1: FIFO full flag.
- `fifo_wr_en`  out  1: FIFO write enable.
- `fifo_wr_data`  out  DATA_WIDTH: FIFO write data.
- `grant_valid`  out  1: high while in GRANT.
- `grant_id`  out  GW: index of the current or most recent grantee.
- `xfer_count`  out  16: total beats written to the FIFO; wraps modulo 2^16.

## Operation

- FSM has two states, IDLE and GRANT.
- **Registered state:**
  - `state`
  - `grant_id`
  - `last_id`, the round-robin pointer
  - `beat_cnt` (width `$clog2(BURST_LEN+1)`)
  - `xfer_count`
- **IDLE:**
  - Winner is the first i with `req_valid[i]=1`, searching from `last_id+1` upward and wrapping modulo `NUM_REQ`.
  - If a winner exists: next state is GRANT, `grant_id`<=winner, `beat_cnt`<=0.
  - Otherwise remain in IDLE.
- **GRANT, transfer:**
  - Transfer condition: `xfer = req_valid[grant_id] & ~fifo_full`.
  - `fifo_wr_en = xfer`.
  - `req_ready[grant_id] = ~fifo_full`; all other ready bits are 0.
  - `fifo_wr_data = req_data[grant_id]` while in GRANT, else 0.
  - On `xfer`: `beat_cnt`+=1 and `xfer_count`+=1.
- **GRANT, release** (go to IDLE, `last_id`<=`grant_id`) when either:
  - `xfer` occurs with `beat_cnt==BURST_LEN-1`; or
  - `req_valid[grant_id]==0`. The requester withdrew; no beat is written.
- **GRANT, stall:** `fifo_full=1` with valid high holds the grant. There is no write and no ready, and neither `beat_cnt` nor the grant changes. A stall never releases the grant.
- Requests from non-granted requesters are ignored until the next IDLE arbitration.
- Outputs that depend on inputs (`fifo_wr_en`, `req_ready`, `fifo_wr_data`) are combinational from registered state plus `req_valid`/`fifo_full`/`req_data`. There are no combinational paths from requester data to control.

## Timing

- **Reset values** (asynchronous on `reset_n` low):
  - `state`=IDLE, `grant_id`=0, `last_id`=NUM_REQ-1 (requester 0 wins first), `beat_cnt`=0, `xfer_count`=0.
  - Hence `grant_valid`=0, `fifo_wr_en`=0, `req_ready`=0, `fifo_wr_data`=0.
- **Grant latency:** a valid seen in IDLE at edge N gives GRANT from edge N; the first write can occur in the cycle after edge N.
- **Throughput:**
  - Within a grant: one beat per cycle while not full.
  - Between grants: exactly one IDLE cycle.
  - Full-burst period for continuous requesters is `BURST_LEN+1` cycles.
- **Reset mid-burst:** the grant is dropped immediately and `fifo_wr_en` goes low asynchronously. Beats already written stay in the FIFO; a partial burst is not resumed.
- **Simultaneous events:**
  - `fifo_full` deasserting in the same cycle as the final burst beat: the beat is written and the grant releases.
  - Grantee valid low while full: the grant releases.
  - `xfer_count` wraps 0xFFFF to 0x0000 with no flag.

## Test plan

- Reset: assert `reset_n`=0 mid-activity -> `fifo_wr_en`=0, `req_ready`=0, `grant_valid`=0, `xfer_count`=0 immediately; after release, requester 0 wins the first arbitration.
- Single requester 2 holds valid for 6 beats (BURST_LEN=4, `fifo_full`=0) -> 4 writes on consecutive cycles, 1 IDLE cycle, 2 more writes; `xfer_count`=6; `grant_id`=2 throughout.
- All four requesters continuously valid -> grant order 0,1,2,3,0,… with 4 writes each and a 5-cycle period; data on `fifo_wr_data` matches the granted slice on each write.
- `fifo_full`=1 for 3 cycles after beat 2 of requester 1's burst -> no `fifo_wr_en`, `req_ready`=0, `grant_id` held at 1; beats 3-4 write after full drops, then release.
- Requester 0 drops valid after 2 beats while requester 3 is valid -> grant releases with `xfer_count`+=2, one IDLE cycle, then requester 3 is granted (search from index 1 finds 3).
- Wrap check: preload by running 65 536 beats -> `xfer_count` reads 0x0000 and the arbiter continues normally.
